cpu_fetch_decode: RTL and testbench

Instruction fetch and decode unit for the 16-bit, 4-register CPU. It reads instruction words from the synchronous instruction ROM (`sync_rom`), holds the program counter, and resolves `JMP` internally. Every other instruction is split into opcode/register/immediate fields and presented to the data path over a valid/ready handshake. It sits between `irom` and `data_path` inside `cpu`, replacing ad-hoc PC logic in the controller.

---
 rtl/cpu_fetch_decode_if.sv | 30 +++
 rtl/cpu_fetch_decode.sv | 113 +++++++++++
 tb/tb_cpu_fetch_decode.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/cpu_fetch_decode_if.sv
// Fetch/decode bus: ROM read port toward irom and the decoded-instruction
// handshake toward the data path.
interface cpu_fetch_decode_if #(
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 12
);
  logic              rom_en;
  logic [AWIDTH-1:0] rom_addr;
  logic [DWIDTH-1:0] rom_data;
  logic              dec_valid;
  logic              dec_ready;
  logic [3:0]        dec_op;
  logic [1:0]        dec_rd;
  logic [1:0]        dec_rs;
  logic [7:0]        dec_imm;
  logic [AWIDTH-1:0] dec_pc;
  logic              dec_illegal;

  modport master (
    output rom_en, rom_addr, dec_valid, dec_op, dec_rd, dec_rs, dec_imm,
           dec_pc, dec_illegal,
    input  rom_data, dec_ready
  );

  modport slave (
    input  rom_en, rom_addr, dec_valid, dec_op, dec_rd, dec_rs, dec_imm,
           dec_pc, dec_illegal,
    output rom_data, dec_ready
  );
endinterface

// File: rtl/cpu_fetch_decode.sv
// Instruction fetch/decode unit: owns the PC, resolves JMP locally and hands
// every other legal instruction to the data path over a valid/ready handshake.
module cpu_fetch_decode #(
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 12
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en_in,
  cpu_fetch_decode_if.master      bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_LATCH = 2'd2,
    S_ISSUE = 2'd3
  } state_t;

  localparam logic [3:0] OP_JMP = 4'hC;

  function automatic logic op_is_illegal(input logic [3:0] op);
    return (op > OP_JMP);
  endfunction

  state_t            state_q, state_d;
  logic [AWIDTH-1:0] pc_q, pc_d;
  logic [DWIDTH-1:0] ir_q, ir_d;
  logic              rom_en_q, rom_en_d;
  logic              dec_valid_q, dec_valid_d;
  logic              dec_illegal_q, dec_illegal_d;
  logic [3:0]        rom_op_s;
  logic [AWIDTH-1:0] pc_inc_s;

  assign rom_op_s = bus.rom_data[15:12];
  assign pc_inc_s = pc_q + {{(AWIDTH-1){1'b0}}, 1'b1};

  // Next-state, PC and IR update logic.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    ir_d          = ir_q;
    dec_illegal_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (en_in) state_d = S_FETCH;
        else       state_d = S_IDLE;
      end
      S_FETCH: begin
        if (en_in) state_d = S_LATCH;
        else       state_d = S_IDLE;
      end
      S_LATCH: begin
        ir_d = bus.rom_data;
        if (rom_op_s == OP_JMP) begin
          pc_d    = {{(AWIDTH-8){1'b0}}, bus.rom_data[7:0]};
          state_d = S_FETCH;
        end else if (op_is_illegal(rom_op_s)) begin
          dec_illegal_d = 1'b1;
          pc_d          = pc_inc_s;
          state_d       = S_FETCH;
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // en_in is deliberately ignored: an issued instruction always completes.
        if (bus.dec_ready) begin
          pc_d    = pc_inc_s;
          state_d = S_FETCH;
        end else begin
          state_d = S_ISSUE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // A FETCH entered with en_in already low issues no read on its way to IDLE.
    rom_en_d    = (state_d == S_FETCH) && en_in;
    dec_valid_d = (state_d == S_ISSUE);
  end

  // State and registered output flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      pc_q          <= {AWIDTH{1'b0}};
      ir_q          <= {DWIDTH{1'b0}};
      rom_en_q      <= 1'b0;
      dec_valid_q   <= 1'b0;
      dec_illegal_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      ir_q          <= ir_d;
      rom_en_q      <= rom_en_d;
      dec_valid_q   <= dec_valid_d;
      dec_illegal_q <= dec_illegal_d;
    end
  end

  assign bus.rom_en      = rom_en_q;
  assign bus.rom_addr    = pc_q;
  assign bus.dec_valid   = dec_valid_q;
  assign bus.dec_illegal = dec_illegal_q;
  assign bus.dec_op      = ir_q[15:12];
  assign bus.dec_rd      = ir_q[11:10];
  assign bus.dec_rs      = ir_q[9:8];
  assign bus.dec_imm     = ir_q[7:0];
  assign bus.dec_pc      = pc_q;

endmodule

// File: tb/tb_cpu_fetch_decode.sv
// Directed bench for cpu_fetch_decode: straight-line fetch, JMP, backpressure,
// illegal opcode, enable drop, PC wrap and reset mid-issue.
module tb_cpu_fetch_decode;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic en_in = 1'b0;

  cpu_fetch_decode_if #(.DWIDTH(16), .AWIDTH(12)) bus ();

  cpu_fetch_decode #(.DWIDTH(16), .AWIDTH(12)) dut (
    .clk   (clk),
    .rst   (rst),
    .en_in (en_in),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [15:0] rom [0:4095];
  logic [11:0] fetch_q [$];
  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int ill_cnt  = 0;
  int last_cyc = 0;
  int hold_n   = 0;
  bit drop_en  = 1'b0;
  bit rst_at   = 1'b0;
  bit gap_chk  = 1'b0;

  // Synchronous ROM model: data valid the cycle after rom_en.
  always @(posedge clk) begin
    if (bus.rom_en) bus.rom_data <= rom[bus.rom_addr];
  end

  // Cycle counter.
  always @(posedge clk) cyc <= cyc + 1;

  // Record issued ROM reads and illegal pulses.
  always @(negedge clk) begin
    if (bus.rom_en) fetch_q.push_back(bus.rom_addr);
    if (bus.dec_illegal) ill_cnt <= ill_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Wait for the next presented instruction, check it, then let it be accepted.
  task automatic check_issue(input string tag, input logic [11:0] pc, input logic [3:0] op,
                             input logic [1:0] rd, input logic [1:0] rs, input logic [7:0] imm);
    int n = 0;
    logic [11:0] nxt;
    nxt = pc + 12'd1;
    while (!bus.dec_valid && n < 30) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_valid"}, 32'(bus.dec_valid), 32'd1);
    check_eq({tag, "_pc"},  32'(bus.dec_pc),  32'(pc));
    check_eq({tag, "_op"},  32'(bus.dec_op),  32'(op));
    check_eq({tag, "_rd"},  32'(bus.dec_rd),  32'(rd));
    check_eq({tag, "_rs"},  32'(bus.dec_rs),  32'(rs));
    check_eq({tag, "_imm"}, 32'(bus.dec_imm), 32'(imm));
    if (gap_chk) check_eq({tag, "_gap"}, 32'(cyc - last_cyc), 32'd3);
    last_cyc = cyc;
    if (drop_en) en_in = 1'b0;
    if (rst_at) begin
      rst = 1'b1;
      bus.dec_ready = 1'b0;
      @(negedge clk);
      check_eq({tag, "_rst_valid"}, 32'(bus.dec_valid), 32'd0);
      check_eq({tag, "_rst_addr"},  32'(bus.rom_addr),  32'd0);
      check_eq({tag, "_rst_romen"}, 32'(bus.rom_en),    32'd0);
      check_eq({tag, "_rst_pc"},    32'(bus.dec_pc),    32'd0);
      return;
    end
    for (int k = 0; k < hold_n; k++) begin
      check_eq({tag, "_hold_valid"}, 32'(bus.dec_valid), 32'd1);
      check_eq({tag, "_hold_op"},    32'(bus.dec_op),    32'(op));
      check_eq({tag, "_hold_imm"},   32'(bus.dec_imm),   32'(imm));
      check_eq({tag, "_hold_addr"},  32'(bus.rom_addr),  32'(pc));
      @(negedge clk);
    end
    if (hold_n > 0) begin
      bus.dec_ready = 1'b1;
      check_eq({tag, "_last_valid"}, 32'(bus.dec_valid), 32'd1);
      check_eq({tag, "_last_addr"},  32'(bus.rom_addr),  32'(pc));
    end
    @(posedge clk);
    #1;
    check_eq({tag, "_drop"},  32'(bus.dec_valid), 32'd0);
    check_eq({tag, "_next"},  32'(bus.rom_addr),  32'(nxt));
  endtask

  initial begin
    int rel;
    int n0;
    int ib;
    for (int i = 0; i < 4096; i++) rom[i] = 16'h0000;
    rom[0]  = 16'h0001; rom[1]  = 16'h0403; rom[2]  = 16'h1800; rom[3]  = 16'h3600;
    rom[4]  = 16'h5B11; rom[5]  = 16'hF123; rom[6]  = 16'h6ABC; rom[7]  = 16'h7000;
    rom[8]  = 16'h8C3F; rom[9]  = 16'hC014; rom[20] = 16'h000A; rom[21] = 16'h9400;
    rom[23] = 16'hA465; rom[4095] = 16'h2C06;
    bus.dec_ready = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_romen",   32'(bus.rom_en),      32'd0);
    check_eq("rst_valid",   32'(bus.dec_valid),   32'd0);
    check_eq("rst_illegal", 32'(bus.dec_illegal), 32'd0);
    check_eq("rst_addr",    32'(bus.rom_addr),    32'd0);
    check_eq("rst_pc",      32'(bus.dec_pc),      32'd0);
    check_eq("rst_op",      32'(bus.dec_op),      32'd0);

    rst = 1'b0; en_in = 1'b1; bus.dec_ready = 1'b1; rel = cyc;
    @(negedge clk);
    check_eq("e1_valid", 32'(bus.dec_valid), 32'd0);
    check_eq("e1_romen", 32'(bus.rom_en),    32'd1);
    @(negedge clk);
    check_eq("e2_valid", 32'(bus.dec_valid), 32'd0);
    @(negedge clk);
    check_eq("e3_valid", 32'(bus.dec_valid), 32'd1);
    check_eq("e3_cyc",   32'(cyc - rel),     32'd3);

    check_issue("i0", 12'd0, 4'h0, 2'd0, 2'd0, 8'h01);
    gap_chk = 1'b1;
    check_issue("i1", 12'd1, 4'h0, 2'd1, 2'd0, 8'h03);
    check_issue("i2", 12'd2, 4'h1, 2'd2, 2'd0, 8'h00);
    gap_chk = 1'b0;
    check_issue("i3", 12'd3, 4'h3, 2'd1, 2'd2, 8'h00);

    // Enable drops while PC 4 is being presented.
    drop_en = 1'b1;
    check_issue("i4", 12'd4, 4'h5, 2'd2, 2'd3, 8'h11);
    drop_en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_eq("off_romen", 32'(bus.rom_en),    32'd0);
      check_eq("off_valid", 32'(bus.dec_valid), 32'd0);
    end
    check_eq("off_addr", 32'(bus.rom_addr), 32'd5);
    n0 = fetch_q.size(); ib = ill_cnt;
    en_in = 1'b1;
    check_issue("i6", 12'd6, 4'h6, 2'd2, 2'd2, 8'hBC);
    check_eq("ill_pulses", 32'(ill_cnt - ib),          32'd1);
    check_eq("ill_nfetch", 32'(fetch_q.size() - n0),   32'd2);
    check_eq("ill_fetch0", 32'(fetch_q[n0]),           32'd5);
    check_eq("ill_fetch1", 32'(fetch_q[n0 + 1]),       32'd6);

    check_issue("i7", 12'd7, 4'h7, 2'd0, 2'd0, 8'h00);
    check_issue("i8", 12'd8, 4'h8, 2'd3, 2'd0, 8'h3F);
    n0 = fetch_q.size();
    check_issue("i20", 12'd20, 4'h0, 2'd0, 2'd0, 8'h0A);
    check_eq("jmp_nfetch", 32'(fetch_q.size() - n0), 32'd2);
    check_eq("jmp_fetch0", 32'(fetch_q[n0]),         32'd9);
    check_eq("jmp_fetch1", 32'(fetch_q[n0 + 1]),     32'd20);
    check_issue("i21", 12'd21, 4'h9, 2'd1, 2'd0, 8'h00);
    check_issue("i22", 12'd22, 4'h0, 2'd0, 2'd0, 8'h00);

    // Five cycles of backpressure on the LDRI at 23.
    bus.dec_ready = 1'b0; hold_n = 5;
    check_issue("i23", 12'd23, 4'hA, 2'd1, 2'd0, 8'h65);
    hold_n = 0;

    for (int p = 24; p < 4095; p++) check_issue("fill", 12'(p), 4'h0, 2'd0, 2'd0, 8'h00);
    check_issue("iFFF", 12'hFFF, 4'h2, 2'd3, 2'd0, 8'h06);
    n0 = fetch_q.size();
    check_issue("wrap0", 12'd0, 4'h0, 2'd0, 2'd0, 8'h01);
    check_eq("wrap_fetch", 32'(fetch_q[n0]), 32'd0);
    check_issue("w1", 12'd1, 4'h0, 2'd1, 2'd0, 8'h03);
    check_issue("w2", 12'd2, 4'h1, 2'd2, 2'd0, 8'h00);
    check_issue("w3", 12'd3, 4'h3, 2'd1, 2'd2, 8'h00);
    check_issue("w4", 12'd4, 4'h5, 2'd2, 2'd3, 8'h11);
    check_issue("w6", 12'd6, 4'h6, 2'd2, 2'd2, 8'hBC);

    // Reset lands while PC 7 is presented.
    rst_at = 1'b1;
    check_issue("w7", 12'd7, 4'h7, 2'd0, 2'd0, 8'h00);
    rst_at = 1'b0;
    rst = 1'b0; bus.dec_ready = 1'b1; rel = cyc;
    check_issue("post_rst", 12'd0, 4'h0, 2'd0, 2'd0, 8'h01);
    check_eq("post_rst_cyc", 32'(last_cyc - rel), 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
